// File: rtl/lsu_pkg.sv
// Shared widths, memory-op encodings and FSM state encoding for the load/store unit.
package lsu_pkg;

    localparam int unsigned LSU_DATA_WIDTH = 32;
    localparam int unsigned LSU_ADDR_WIDTH = 5;

    typedef enum logic [2:0] {
        MEM_B  = 3'b000,
        MEM_H  = 3'b001,
        MEM_W  = 3'b010,
        MEM_BU = 3'b100,
        MEM_HU = 3'b101
    } mem_op_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2
    } lsu_state_e;

    // Size is carried in op[1:0]; unlisted codes are treated as word accesses.
    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] addr_lo);
        case (op[1:0])
            2'b00:   return 1'b0;
            2'b01:   return addr_lo[0];
            default: return addr_lo != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Data-memory request/response channel between the LSU (master) and memory (slave).
interface lsu_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  dmem_req_valid;
    logic                  dmem_req_ready;
    logic                  dmem_wen;
    logic [DATA_WIDTH-1:0] dmem_addr;
    logic [DATA_WIDTH-1:0] dmem_wdata;
    logic [3:0]            dmem_wmask;
    logic                  dmem_rsp_valid;
    logic [DATA_WIDTH-1:0] dmem_rdata;

    modport master (
        output dmem_req_valid, dmem_wen, dmem_addr, dmem_wdata, dmem_wmask,
        input  dmem_req_ready, dmem_rsp_valid, dmem_rdata
    );

    modport slave (
        input  dmem_req_valid, dmem_wen, dmem_addr, dmem_wdata, dmem_wmask,
        output dmem_req_ready, dmem_rsp_valid, dmem_rdata
    );
endinterface

// File: rtl/lsu_load_align.sv
// Combinational load formatter: lane select by address offset, then sign/zero extension.
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = LSU_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            addr_lo,
    input  logic [2:0]            mem_op,
    output logic [DATA_WIDTH-1:0] data_out
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        data_out = rdata;
        case (mem_op)
            MEM_B:   data_out = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
            MEM_BU:  data_out = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
            MEM_H:   data_out = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
            MEM_HU:  data_out = {{(DATA_WIDTH-16){1'b0}}, half_sel};
            default: data_out = rdata;
        endcase
    end
endmodule

// File: rtl/lsu.sv
// Load/store unit: MEM pipeline stage driving a valid/ready data-memory port and the WB registers.
module lsu
    import lsu_pkg::*;
#(
    parameter int DATA_WIDTH = LSU_DATA_WIDTH,
    parameter int ADDR_WIDTH = LSU_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  MemReg_valid,
    input  logic                  MemReg_MemRd,
    input  logic                  MemReg_MemWr,
    input  logic                  MemReg_MemtoReg,
    input  logic                  MemReg_RegWr,
    input  logic                  MemReg_PCsrc,
    input  logic                  ex_diffen,
    input  logic [2:0]            MemReg_MemOp,
    input  logic [ADDR_WIDTH-1:0] MemReg_Regrd,
    input  logic [DATA_WIDTH-1:0] MemReg_ALUout,
    input  logic [DATA_WIDTH-1:0] MemReg_StoreData,
    input  logic [DATA_WIDTH-1:0] MemReg_PC,
    input  logic [DATA_WIDTH-1:0] MemReg_Instr,
    output logic                  lsu_ready,
    lsu_if.master                 dmem,
    output logic                  WBReg_MemtoReg,
    output logic                  WBReg_RegWr,
    output logic                  WBReg_PCsrc,
    output logic                  wb_valid,
    output logic                  lsu_misalign,
    output logic [ADDR_WIDTH-1:0] WBReg_Regrd,
    output logic [DATA_WIDTH-1:0] WBReg_ALUout,
    output logic [DATA_WIDTH-1:0] WBReg_DataOut,
    output logic [DATA_WIDTH-1:0] WBReg_PC,
    output logic [DATA_WIDTH-1:0] WBReg_Instr
);
    lsu_state_e state, state_nxt;

    logic                  c_wen, c_memtoreg, c_regwr, c_pcsrc, c_diffen;
    logic [2:0]            c_op;
    logic [3:0]            c_wmask;
    logic [ADDR_WIDTH-1:0] c_regrd;
    logic [DATA_WIDTH-1:0] c_addr, c_wdata, c_pc, c_instr;

    logic                  accept, is_mem, misal, fast_done, mem_start, mem_done;
    logic [3:0]            mask_in;
    logic [DATA_WIDTH-1:0] wdata_in, load_data;

    assign lsu_ready = (state == IDLE);
    assign accept    = MemReg_valid && lsu_ready;
    assign is_mem    = MemReg_MemRd || MemReg_MemWr;
    assign misal     = is_misaligned(MemReg_MemOp, MemReg_ALUout[1:0]);
    assign fast_done = accept && (!is_mem || misal);
    assign mem_start = accept && is_mem && !misal;
    assign mem_done  = (state == WAIT_RSP) && dmem.dmem_rsp_valid;

    always_comb begin
        mask_in  = 4'b1111;
        wdata_in = MemReg_StoreData;
        case (MemReg_MemOp[1:0])
            2'b00: begin
                mask_in  = 4'b0001 << MemReg_ALUout[1:0];
                wdata_in = {4{MemReg_StoreData[7:0]}};
            end
            2'b01: begin
                mask_in  = 4'b0011 << MemReg_ALUout[1:0];
                wdata_in = {2{MemReg_StoreData[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (mem_start) state_nxt = REQ;
            REQ:      if (dmem.dmem_req_ready) state_nxt = WAIT_RSP;
            WAIT_RSP: if (dmem.dmem_rsp_valid) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Captured operands only change on acceptance, which keeps the request stable while stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c_op <= '0; c_addr <= '0; c_wen <= 1'b0; c_wdata <= '0; c_wmask <= '0;
            c_regrd <= '0; c_pc <= '0; c_instr <= '0; c_memtoreg <= 1'b0;
            c_regwr <= 1'b0; c_pcsrc <= 1'b0; c_diffen <= 1'b0;
        end else if (mem_start) begin
            c_op       <= MemReg_MemOp;
            c_addr     <= MemReg_ALUout;
            c_wen      <= MemReg_MemWr;
            c_wdata    <= wdata_in;
            c_wmask    <= mask_in;
            c_regrd    <= MemReg_Regrd;
            c_pc       <= MemReg_PC;
            c_instr    <= MemReg_Instr;
            c_memtoreg <= MemReg_MemtoReg;
            c_regwr    <= MemReg_RegWr;
            c_pcsrc    <= MemReg_PCsrc;
            c_diffen   <= ex_diffen;
        end
    end

    assign dmem.dmem_req_valid = (state == REQ);
    assign dmem.dmem_addr      = {c_addr[DATA_WIDTH-1:2], 2'b00};
    assign dmem.dmem_wen       = c_wen;
    assign dmem.dmem_wdata     = c_wdata;
    assign dmem.dmem_wmask     = c_wmask;

    lsu_load_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .rdata    (dmem.dmem_rdata),
        .addr_lo  (c_addr[1:0]),
        .mem_op   (c_op),
        .data_out (load_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            WBReg_MemtoReg <= 1'b0; WBReg_RegWr <= 1'b0; WBReg_PCsrc <= 1'b0;
            wb_valid <= 1'b0; lsu_misalign <= 1'b0; WBReg_Regrd <= '0;
            WBReg_ALUout <= '0; WBReg_DataOut <= '0; WBReg_PC <= '0; WBReg_Instr <= '0;
        end else begin
            wb_valid     <= 1'b0;
            WBReg_RegWr  <= 1'b0;
            lsu_misalign <= 1'b0;
            if (fast_done) begin
                WBReg_MemtoReg <= MemReg_MemtoReg;
                WBReg_RegWr    <= MemReg_RegWr && !is_mem;
                WBReg_PCsrc    <= MemReg_PCsrc;
                WBReg_Regrd    <= MemReg_Regrd;
                WBReg_ALUout   <= MemReg_ALUout;
                WBReg_DataOut  <= '0;
                WBReg_PC       <= MemReg_PC;
                WBReg_Instr    <= MemReg_Instr;
                wb_valid       <= ex_diffen;
                lsu_misalign   <= is_mem;
            end else if (mem_done) begin
                WBReg_MemtoReg <= c_memtoreg;
                WBReg_RegWr    <= c_regwr;
                WBReg_PCsrc    <= c_pcsrc;
                WBReg_Regrd    <= c_regrd;
                WBReg_ALUout   <= c_addr;
                WBReg_DataOut  <= c_wen ? '0 : load_data;
                WBReg_PC       <= c_pc;
                WBReg_Instr    <= c_instr;
                wb_valid       <= c_diffen;
            end
        end
    end
endmodule
